// File: rtl/shift_sequencer_pkg.sv
// Shared types and defaults for the shift sequencer.
//   state_t       : sequencer FSM states
//   DEF_*         : default word, divider and word-counter widths
//   bitcnt_width  : width of the bit index for a given word width
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIVW  = 8;
    localparam int DEF_CNTW  = 16;

    function automatic int bitcnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_datapath.sv
// Parallel-load, left-shifting register; MSB is the serial bit.
//   clk, reset : clock and synchronous active-high reset (clears register)
//   load       : capture d (wins over shift)
//   shift      : shift left by one, zero fill
//   d          : parallel load word
//   q_msb      : current MSB of the register
module shift_datapath
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q_msb
);

    logic [WIDTH-1:0] sreg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
        end else if (load) begin
            sreg <= d;
        end else if (shift) begin
            sreg <= {sreg[WIDTH-2:0], 1'b0};
        end
    end

    assign q_msb = sreg[WIDTH-1];

endmodule

// File: rtl/shift_sequencer.sv
// Serializes words MSB-first with a programmable bit period.
//   clk, reset : clock and synchronous active-high reset
//   div        : bit period minus one, captured when a word is accepted
//   in_data    : word to serialize
//   in_valid   : producer has a word
//   in_ready   : sequencer can accept (depends on state only)
//   sout       : serial data, MSB first, 0 when not shifting
//   busy       : word transfer in progress
//   done       : one-cycle pulse after the last bit period
//   bitcnt     : index of the bit on sout (0 = MSB)
//   sent       : completed-word counter, wraps
//
// state | meaning
// IDLE  | waiting for a word
// SHIFT | driving bits; divcnt paces each bit period
// DONE  | one-cycle completion pulse; may accept the next word
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIVW  = DEF_DIVW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DIVW-1:0]                 div,
    input  logic [WIDTH-1:0]                in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            sout,
    output logic                            busy,
    output logic                            done,
    output logic [bitcnt_width(WIDTH)-1:0]  bitcnt,
    output logic [CNTW-1:0]                 sent
);

    localparam int             BCW      = bitcnt_width(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    state_t          state, state_nxt;
    logic [DIVW-1:0] div_q;
    logic [DIVW-1:0] divcnt;
    logic [BCW-1:0]  bitcnt_q;
    logic            accept;
    logic            tick;
    logic            last;
    logic            q_msb;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        tick      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (divcnt == '0) begin
                    if (bitcnt_q == LAST_BIT) begin
                        last      = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        tick = 1'b1;
                    end
                end
            end
            DONE: begin
                done     = 1'b1;
                in_ready = 1'b1;
                // Back-to-back: a waiting word goes straight into SHIFT.
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Divider, bit index and word counter. In SHIFT with divcnt != 0 neither
    // tick nor last is set, so the final branch is the plain countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            divcnt   <= '0;
            bitcnt_q <= '0;
            sent     <= '0;
        end else begin
            if (accept) begin
                div_q    <= div;
                divcnt   <= div;
                bitcnt_q <= '0;
            end else if (tick) begin
                divcnt   <= div_q;
                bitcnt_q <= bitcnt_q + 1'b1;
            end else if (last) begin
                bitcnt_q <= '0;
            end else if (state == SHIFT) begin
                divcnt <= divcnt - 1'b1;
            end
            if (last) begin
                sent <= sent + 1'b1;
            end
        end
    end

    shift_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (tick),
        .d     (in_data),
        .q_msb (q_msb)
    );

    assign sout   = (state == SHIFT) ? q_msb : 1'b0;
    assign bitcnt = (state == SHIFT) ? bitcnt_q : '0;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases plus random words, checked
// against a bit-period model (bit index = cycle / (div+1)). A second
// instance with a 2-bit word counter shares the stimulus to cover wrap.
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int DIVW  = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [DIVW-1:0]  div;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready, sout, busy, done;
    logic [2:0]       bitcnt;
    logic [15:0]      sent;
    logic             in_ready2, sout2, busy2, done2;
    logic [2:0]       bitcnt2;
    logic [1:0]       sent2;

    int n_checks = 0;
    int n_errors = 0;
    int exp_sent = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.WIDTH(WIDTH), .DIVW(DIVW), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .div(div), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .sout(sout), .busy(busy),
        .done(done), .bitcnt(bitcnt), .sent(sent)
    );

    shift_sequencer #(.WIDTH(WIDTH), .DIVW(DIVW), .CNTW(2)) dut_wrap (
        .clk(clk), .reset(reset), .div(div), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready2), .sout(sout2), .busy(busy2),
        .done(done2), .bitcnt(bitcnt2), .sent(sent2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, ".busy"},     32'(busy),     32'd0);
        check_eq({tag, ".done"},     32'(done),     32'd0);
        check_eq({tag, ".sout"},     32'(sout),     32'd0);
        check_eq({tag, ".bitcnt"},   32'(bitcnt),   32'd0);
        check_eq({tag, ".sent"},     32'(sent),     32'(exp_sent % 65536));
        check_eq({tag, ".sent2"},    32'(sent2),    32'(exp_sent % 4));
    endtask

    task automatic present(input logic [WIDTH-1:0] w, input int d);
        in_valid = 1'b1;
        in_data  = w;
        div      = DIVW'(d);
        check_eq("present.in_ready", 32'(in_ready), 32'd1);
    endtask

    // Precondition: word w with divider d is presented in a cycle with in_ready=1.
    // Returns in the DONE cycle, with the next word presented if chain is set.
    task automatic serialize(input logic [WIDTH-1:0] w, input int d, input bit chain,
                             input logic [WIDTH-1:0] nw, input int nd);
        int idx;
        step();
        in_valid = 1'b0;
        for (int t = 0; t < WIDTH * (d + 1); t++) begin
            idx = t / (d + 1);
            check_eq("shift.sout",     32'(sout),     32'(w[WIDTH-1-idx]));
            check_eq("shift.bitcnt",   32'(bitcnt),   32'(idx));
            check_eq("shift.busy",     32'(busy),     32'd1);
            check_eq("shift.in_ready", 32'(in_ready), 32'd0);
            check_eq("shift.done",     32'(done),     32'd0);
            check_eq("shift.sent",     32'(sent),     32'(exp_sent % 65536));
            in_data = WIDTH'($urandom);
            div     = DIVW'($urandom);
            step();
        end
        exp_sent++;
        check_eq("done.done",     32'(done),     32'd1);
        check_eq("done.done2",    32'(done2),    32'd1);
        check_eq("done.sout",     32'(sout),     32'd0);
        check_eq("done.busy",     32'(busy),     32'd0);
        check_eq("done.in_ready", 32'(in_ready), 32'd1);
        check_eq("done.bitcnt",   32'(bitcnt),   32'd0);
        check_eq("done.sent",     32'(sent),     32'(exp_sent % 65536));
        check_eq("done.sent2",    32'(sent2),    32'(exp_sent % 4));
        if (chain) begin
            in_valid = 1'b1;
            in_data  = nw;
            div      = DIVW'(nd);
        end else begin
            in_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] cur_w, nxt_w;
        int               cur_d, nxt_d, rd;
        bit               chain;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        div      = '0;
        step();
        step();
        check_idle("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle("idle");
        end

        // Single word at full rate.
        present(8'hA5, 0);
        serialize(8'hA5, 0, 1'b0, '0, 0);
        step();
        check_idle("after_a5");

        // Divided rate; div/in_data are scrambled during SHIFT.
        present(8'h81, 2);
        serialize(8'h81, 2, 1'b0, '0, 0);
        step();
        check_idle("after_81");

        // Back-to-back with in_valid held through DONE.
        present(8'hFF, 0);
        serialize(8'hFF, 0, 1'b1, 8'h00, 0);
        serialize(8'h00, 0, 1'b0, '0, 0);
        step();
        check_idle("after_b2b");

        // Reset at bit 4, with in_valid also high to show reset wins.
        present(8'hF0, 1);
        step();
        in_valid = 1'b0;
        for (int t = 0; t < 4 * 2; t++) begin
            check_eq("abort.sout", 32'(sout), 32'(t < 8 ? 1 : 0));
            step();
        end
        check_eq("abort.bitcnt", 32'(bitcnt), 32'd4);
        check_eq("abort.sout4",  32'(sout),   32'd0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        step();
        exp_sent = 0;
        check_idle("abort_rst");
        reset    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("abort_idle");
        end
        present(8'h96, 0);
        serialize(8'h96, 0, 1'b0, '0, 0);
        step();
        check_idle("after_abort");

        // Random words, random dividers, random chaining and gaps.
        cur_w = WIDTH'($urandom);
        cur_d = int'($urandom_range(0, 3));
        present(cur_w, cur_d);
        for (int i = 0; i < 24; i++) begin
            nxt_w = WIDTH'($urandom);
            nxt_d = int'($urandom_range(0, 3));
            chain = 1'($urandom_range(0, 1));
            serialize(cur_w, cur_d, chain, nxt_w, nxt_d);
            if (!chain) begin
                rd = int'($urandom_range(1, 3));
                for (int g = 0; g < rd; g++) begin
                    step();
                    check_idle("rand_gap");
                end
                present(nxt_w, nxt_d);
            end
            cur_w = nxt_w;
            cur_d = nxt_d;
        end
        serialize(cur_w, cur_d, 1'b0, '0, 0);
        step();
        check_idle("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
